// File: rtl/sweep_vpp_seq.sv
// sweep_vpp_seq: amplitude-frequency sweep sequencer.
// It steps the sweep DDS control word across last_idx+1 points.
// At each point it waits settle_cycles, then waits for a new Vpp report from
// the peak detector. The result goes into an on-chip point buffer that the
// Nios reads back through a registered read port.
//
// Ports:
//   clk            system clock (CLK_100M)
//   rst            asynchronous reset, active-high
//   start/abort    one-cycle control pulses (abort wins over start)
//   kw_start       control word of point 0
//   kw_step        per-point increment (wraps mod 2^KW_W)
//   last_idx       index of the final point
//   settle_cycles  settle delay after each control-word change
//   vpp/vpp_found  peak detector result and update flag (sample-clock domain)
//   kw_out         control word to the sweep DDS
//   busy           sweep in progress
//   done           one-cycle pulse on normal completion
//   point_idx      index of the point currently being measured
//   err_cnt        number of timeouts in the last sweep
//   rd_addr        buffer read address
//   rd_data        {timeout_flag, vpp}, one cycle after rd_addr
//
// Build option: define VPP_AVG_EN to average 2^AVG_LOG2 measurements per point.
module sweep_vpp_seq #(
  parameter int KW_W     = 32,
  parameter int VPP_W    = 12,
  parameter int ADDR_W   = 8,
  parameter int SETTLE_W = 24,
  parameter int TIMEOUT  = 10000000,
  parameter int AVG_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [KW_W-1:0]     kw_start,
  input  logic [KW_W-1:0]     kw_step,
  input  logic [ADDR_W-1:0]   last_idx,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic [VPP_W-1:0]    vpp,
  input  logic                vpp_found,
  output logic [KW_W-1:0]     kw_out,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   point_idx,
  output logic [ADDR_W:0]     err_cnt,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [VPP_W:0]      rd_data
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_STORE   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [2:0]          state;
  logic                found_p0, found_p1, found_p2;
  logic                found_evt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic                timeout_hit;
  logic                wr_en;
  logic [VPP_W-1:0]    data_r;
  logic                flag_r;
  logic [VPP_W:0]      mem [0:(2**ADDR_W)-1];

`ifdef VPP_AVG_EN
  localparam int ACC_W = VPP_W + AVG_LOG2;
  localparam logic [AVG_LOG2:0] MEAS_LAST = (AVG_LOG2+1)'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic [AVG_LOG2:0] meas_cnt;
  logic              meas_last;

  function automatic logic [VPP_W-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
    logic [ACC_W-1:0] sh;
    sh = sum >> AVG_LOG2;
    return sh[VPP_W-1:0];
  endfunction

  assign acc_sum   = acc + ACC_W'(vpp);
  assign meas_last = (meas_cnt == MEAS_LAST);
`endif

  // Only a rising edge of the synchronised flag counts as a new measurement.
  assign found_evt   = found_p1 & ~found_p2;
  assign timeout_hit = (state == S_WAIT) && !found_evt && (to_cnt == TO_LAST);
  assign wr_en       = (state == S_STORE) && !abort;
  assign done        = (state == S_DONE);

  // Stage p0/p1: vpp_found synchroniser; p2: edge-detect history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      kw_out     <= '0;
      point_idx  <= '0;
      err_cnt    <= '0;
      busy       <= 1'b0;
      settle_cnt <= '0;
      to_cnt     <= '0;
      found_p0   <= 1'b0;
      found_p1   <= 1'b0;
      found_p2   <= 1'b0;
`ifdef VPP_AVG_EN
      meas_cnt   <= '0;
`endif
    end else begin
      found_p0 <= vpp_found;
      found_p1 <= found_p0;
      found_p2 <= found_p1;
      if (abort && (state != S_IDLE)) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              kw_out     <= kw_start;
              point_idx  <= '0;
              err_cnt    <= '0;
              busy       <= 1'b1;
              settle_cnt <= settle_cycles;
              state      <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (settle_cnt == '0) begin
              to_cnt <= '0;
`ifdef VPP_AVG_EN
              meas_cnt <= '0;
`endif
              state  <= S_WAIT;
            end else begin
              settle_cnt <= settle_cnt - SETTLE_W'(1);
            end
          end
          S_WAIT: begin
            if (found_evt) begin
              state <= S_CAPTURE;
            end else if (to_cnt == TO_LAST) begin
              err_cnt <= err_cnt + (ADDR_W+1)'(1);
              state   <= S_STORE;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
          S_CAPTURE: begin
`ifdef VPP_AVG_EN
            if (meas_last) begin
              state <= S_STORE;
            end else begin
              meas_cnt <= meas_cnt + (AVG_LOG2+1)'(1);
              to_cnt   <= '0;
              state    <= S_WAIT;
            end
`else
            state <= S_STORE;
`endif
          end
          S_STORE: begin
            if (point_idx == last_idx) begin
              state <= S_DONE;
            end else begin
              point_idx  <= point_idx + ADDR_W'(1);
              kw_out     <= kw_out + kw_step;
              settle_cnt <= settle_cycles;
              state      <= S_SETTLE;
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Result datapath and point buffer (no reset on data)
  always_ff @(posedge clk) begin
    case (state)
`ifdef VPP_AVG_EN
      S_SETTLE: acc <= '0;
`endif
      S_WAIT: begin
        if (timeout_hit) begin
          data_r <= '0;
          flag_r <= 1'b1;
        end
      end
      S_CAPTURE: begin
`ifdef VPP_AVG_EN
        acc <= acc_sum;
        if (meas_last) begin
          data_r <= avg_trunc(acc_sum);
          flag_r <= 1'b0;
        end
`else
        data_r <= vpp;
        flag_r <= 1'b0;
`endif
      end
      default: ;
    endcase
    if (wr_en) begin
      mem[point_idx] <= {flag_r, data_r};
    end
  end

  // Read port: registered, returns old data on a same-address write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_sweep_vpp_seq.sv
module tb_sweep_vpp_seq;
  localparam int KW_W     = 32;
  localparam int VPP_W    = 12;
  localparam int ADDR_W   = 8;
  localparam int SETTLE_W = 24;
  localparam int TIMEOUT  = 50;
  localparam int AVG_LOG2 = 2;
`ifdef VPP_AVG_EN
  localparam int NMEAS = 1 << AVG_LOG2;
`else
  localparam int NMEAS = 1;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic [KW_W-1:0]     kw_start = '0;
  logic [KW_W-1:0]     kw_step = '0;
  logic [ADDR_W-1:0]   last_idx = '0;
  logic [SETTLE_W-1:0] settle_cycles = '0;
  logic [VPP_W-1:0]    vpp = '0;
  logic                vpp_found = 1'b0;
  logic [KW_W-1:0]     kw_out;
  logic                busy;
  logic                done;
  logic [ADDR_W-1:0]   point_idx;
  logic [ADDR_W:0]     err_cnt;
  logic [ADDR_W-1:0]   rd_addr = '0;
  logic [VPP_W:0]      rd_data;

  int vectors  = 0;
  int errs     = 0;
  int done_cnt = 0;

  sweep_vpp_seq #(
    .KW_W(KW_W), .VPP_W(VPP_W), .ADDR_W(ADDR_W), .SETTLE_W(SETTLE_W),
    .TIMEOUT(TIMEOUT), .AVG_LOG2(AVG_LOG2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .kw_start(kw_start), .kw_step(kw_step), .last_idx(last_idx),
    .settle_cycles(settle_cycles), .vpp(vpp), .vpp_found(vpp_found),
    .kw_out(kw_out), .busy(busy), .done(done), .point_idx(point_idx),
    .err_cnt(err_cnt), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Peak detector model: new Vpp plus a 3-cycle high flag, d cycles from now
  task automatic emit(input logic [VPP_W-1:0] v, input int d);
    tick(d);
    vpp = v;
    vpp_found = 1'b1;
    tick(3);
    vpp_found = 1'b0;
  endtask

  task automatic meas_point(input logic [VPP_W-1:0] v);
    for (int m = 0; m < NMEAS; m++) emit(v, (m == 0) ? 10 : 4);
  endtask

  task automatic wait_idx(input logic [ADDR_W-1:0] i, input string tag);
    int n;
    n = 0;
    while (point_idx !== i && n < 400) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(point_idx), 32'(i));
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, output logic [VPP_W:0] d);
    rd_addr = a;
    tick(1);
    d = rd_data;
  endtask

  initial begin
    logic [VPP_W:0] d;
    int dc;

    // Reset state
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_kw_out", kw_out, 32'd0);
    chk("rst_point_idx", 32'(point_idx), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);

    // Basic sweep: 4 points, vpp = 0x100+i
    kw_start = 32'h0000_0100; kw_step = 32'h10; last_idx = 8'd3; settle_cycles = 24'd5;
    dc = done_cnt;
    pulse_start();
    chk("basic_busy", 32'(busy), 32'd1);
    chk("basic_kw0", kw_out, 32'h100);
    meas_point(12'h100);
    for (int i = 1; i < 4; i++) begin
      wait_idx(8'(i), "basic_idx");
      chk("basic_kw", kw_out, 32'h100 + 32'(16 * i));
      meas_point(12'(12'h100 + i));
    end
    wait_done("basic_done");
    tick(1);
    chk("basic_busy_after", 32'(busy), 32'd0);
    chk("basic_done_count", 32'(done_cnt - dc), 32'd1);
    chk("basic_err_cnt", 32'(err_cnt), 32'd0);
    chk("basic_kw_hold", kw_out, 32'h130);
    for (int i = 0; i < 4; i++) begin
      rd(8'(i), d);
      chk("basic_mem", 32'(d), 32'h100 + 32'(i));
    end

    // Idle: vpp_found activity must not write the buffer
    emit(12'hABC, 2);
    emit(12'hABC, 4);
    tick(5);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_idx", 32'(point_idx), 32'd3);
    for (int i = 0; i < 4; i++) begin
      rd(8'(i), d);
      chk("idle_mem", 32'(d), 32'h100 + 32'(i));
    end

    // Timeout at point 2
    pulse_start();
    chk("to_err_clear", 32'(err_cnt), 32'd0);
    meas_point(12'h100);
    wait_idx(8'd1, "to_idx1");
    meas_point(12'h101);
    wait_idx(8'd2, "to_idx2");
    wait_idx(8'd3, "to_idx3");
    chk("to_err_mid", 32'(err_cnt), 32'd1);
    meas_point(12'h103);
    wait_done("to_done");
    tick(1);
    chk("to_err_cnt", 32'(err_cnt), 32'd1);
    rd(8'd2, d);
    chk("to_mem2", 32'(d), 32'h1000);
    rd(8'd3, d);
    chk("to_mem3", 32'(d), 32'h103);

    // Settle masking: edge during SETTLE ignored
    last_idx = 8'd0;
    pulse_start();
    emit(12'hFFF, 1);
    meas_point(12'h0A5);
    wait_done("mask_done");
    tick(1);
    rd(8'd0, d);
    chk("mask_mem0", 32'(d), 32'h0A5);

    // Abort at point 2
    last_idx = 8'd3;
    pulse_start();
    meas_point(12'h200);
    wait_idx(8'd1, "abort_idx1");
    meas_point(12'h201);
    wait_idx(8'd2, "abort_idx2");
    dc = done_cnt;
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    emit(12'h777, 2);
    tick(20);
    chk("abort_no_done", 32'(done_cnt - dc), 32'd0);
    chk("abort_kw_hold", kw_out, 32'h120);
    rd(8'd1, d);
    chk("abort_mem1", 32'(d), 32'h201);
    rd(8'd2, d);
    chk("abort_mem2", 32'(d), 32'h1000);

    // Restart after abort begins at point 0
    pulse_start();
    chk("restart_idx", 32'(point_idx), 32'd0);
    chk("restart_kw", kw_out, 32'h100);
    meas_point(12'h300);
    for (int i = 1; i < 4; i++) begin
      wait_idx(8'(i), "restart_idx_n");
      meas_point(12'(12'h300 + i));
    end
    wait_done("restart_done");
    tick(1);
    rd(8'd2, d);
    chk("restart_mem2", 32'(d), 32'h302);

    // Control word wraps modulo 2^32
    kw_start = 32'hFFFF_FFF0; kw_step = 32'h20; last_idx = 8'd1;
    pulse_start();
    chk("wrap_kw0", kw_out, 32'hFFFF_FFF0);
    meas_point(12'h050);
    wait_idx(8'd1, "wrap_idx1");
    chk("wrap_kw1", kw_out, 32'h0000_0010);
    meas_point(12'h051);
    wait_done("wrap_done");
    tick(1);

    // start and abort together: stays idle
    start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", 32'(busy), 32'd0);
    tick(3);
    chk("sa_busy_later", 32'(busy), 32'd0);
    chk("sa_kw_hold", kw_out, 32'h10);
    chk("sa_idx_hold", 32'(point_idx), 32'd1);

`ifdef VPP_AVG_EN
    // Averaging: 10,11,12,14 -> 47>>2 = 11
    last_idx = 8'd0;
    pulse_start();
    emit(12'd10, 10);
    emit(12'd11, 4);
    emit(12'd12, 4);
    emit(12'd14, 4);
    wait_done("avg_done");
    tick(1);
    rd(8'd0, d);
    chk("avg_mem0", 32'(d), 32'd11);
`endif

    // Asynchronous reset mid-sweep
    last_idx = 8'd3; kw_start = 32'h100; kw_step = 32'h10;
    pulse_start();
    tick(3);
    dc = done_cnt;
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_kw", kw_out, 32'd0);
    chk("arst_rd_data", 32'(rd_data), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(3);
    chk("arst_no_done", 32'(done_cnt - dc), 32'd0);
    chk("arst_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/sweep_vpp_seq.md
Name: sweep_vpp_seq

Overview:
Hardware sweep sequencer for the amplitude-frequency measurement path.
- Steps the sweep DDS frequency control word across N points.
- Waits for the output to settle at each point, then waits for the peak detector to report a new Vpp.
- Stores each Vpp in an on-chip point buffer.
- The Nios reads the finished curve back through a registered read port, so it no longer paces every point in software.

Parameters:
KW_W, 32, frequency control word width (matches sweep DDS KW)
VPP_W, 12, Vpp width from peak detector
ADDR_W, 8, point buffer address width (max 2^ADDR_W points)
SETTLE_W, 24, settle counter width
TIMEOUT, 10000000, clk cycles to wait for vpp_found per measurement (100 ms at 100 MHz)
AVG_LOG2, 2, log2 of measurements averaged per point (used only with VPP_AVG_EN)

Ports:
clk  in  1  system clock (CLK_100M)
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse; begins sweep when idle
abort  in  1  one-cycle pulse; stops sweep
kw_start  in  KW_W  control word of point 0
kw_step  in  KW_W  control word increment per point
last_idx  in  ADDR_W  index of final point (points = last_idx+1)
settle_cycles  in  SETTLE_W  clk cycles to wait after each kw change
vpp  in  VPP_W  Vpp from peak detector (sample-clock domain, held stable between updates)
vpp_found  in  1  peak detector update flag (sample-clock domain)
kw_out  out  KW_W  control word to sweep DDS
busy  out  1  sweep in progress
done  out  1  one-cycle pulse on normal completion
point_idx  out  ADDR_W  index currently being measured
err_cnt  out  ADDR_W+1  timeouts in last sweep
rd_addr  in  ADDR_W  buffer read address
rd_data  out  VPP_W+1  {timeout_flag, vpp}; 1-cycle read latency

Behaviour:
- Reset values:
  - kw_out, point_idx, err_cnt, rd_data = 0.
  - busy = 0, done = 0.
  - state = IDLE.
  - Buffer contents are not reset.
- vpp_found passes through a 2-FF synchroniser. A rising edge of the synchronised flag is one "found event". vpp is sampled on the cycle after the edge is detected.
- FSM:
  - IDLE: on start (and no abort):
    - kw_out<=kw_start, point_idx<=0, err_cnt<=0, busy<=1.
    - Go to SETTLE.
    - start while busy is ignored.
  - SETTLE:
    - Settle counter is loaded with settle_cycles on entry and decremented each clk; found events are ignored.
    - Go to WAIT when the counter is 0. settle_cycles=0 gives one cycle in SETTLE.
  - WAIT:
    - Timeout counter cleared on entry.
    - On a found event: go to CAPTURE.
    - If the counter reaches TIMEOUT-1 with no event: set flag, err_cnt++, go to STORE with data 0.
  - CAPTURE: latch vpp into the data register, flag=0, go to STORE.
  - STORE: mem[point_idx] <= {flag, data}. Then:
    - If point_idx==last_idx: go to DONE.
    - Otherwise: point_idx++, kw_out<=kw_out+kw_step (mod 2^KW_W, wrap silently), go to SETTLE.
  - DONE: done=1 for one cycle, busy<=0, go to IDLE. kw_out and point_idx hold their last values.
- Abort:
  - In any non-IDLE state: state<=IDLE next cycle, busy<=0, no done pulse, no further writes.
  - Buffer entries already written remain; kw_out holds.
  - abort and start in the same cycle: abort wins.
- Read port:
  - rd_data <= mem[rd_addr] each clk; valid at any time.
  - Read and write to the same address in the same cycle returns old data.
- The buffer is inferred as a simple dual-port RAM (one write, one read).
- Asynchronous reset mid-sweep returns to IDLE immediately; no done pulse.

Optional Feature:
VPP_AVG_EN
- Defined: each point takes 2^AVG_LOG2 measurements.
  - Each measurement goes through WAIT→CAPTURE, then back to WAIT until the count is complete.
  - The accumulator is VPP_W+AVG_LOG2 bits, cleared in SETTLE.
  - Stored data = accumulator >> AVG_LOG2 (truncate).
  - A timeout on any measurement ends the point at once: stores 0 with flag=1, err_cnt++.
- Not defined: one measurement per point as described above. The accumulator and its logic are absent.

Test Plan:
- Reset then idle: rd_data=0, busy=0, kw_out=0; vpp_found toggling causes no writes.
- Basic sweep:
  - Stimulus: kw_start=0x00000100, kw_step=0x10, last_idx=3, settle_cycles=5, model emits vpp=0x100+i a fixed delay after each kw change.
  - Expect: kw_out sequence 0x100,0x110,0x120,0x130; mem[0..3]=0x100..0x103 with flag 0; single done pulse; busy low after.
- Timeout: no vpp_found at point 2 (TIMEOUT reduced to 50) -> mem[2]=0x1000, err_cnt=1, sweep continues to completion.
- Settle masking: vpp_found edge during SETTLE with vpp=0xFFF, later edge with vpp=0x0A5 -> stored 0x0A5.
- Abort at point_idx=2 -> busy low next cycle, no done, mem[2] unchanged, restart with start works from point 0.
- Wrap and edge cases:
  - kw_start=0xFFFFFFF0, kw_step=0x20 -> second kw_out=0x00000010.
  - start+abort same cycle -> stays IDLE.
  - VPP_AVG_EN with 4 readings 10,11,12,14 -> stored 11.
